des_sched: RTL
==============

DES_SCHED -- requirements
Module: des_sched

Interface
REQ-001 Parameter N, default 4, number of attached cracker cores (1..16).
REQ-002 Parameter CHUNKW, default 24, log2 of keys per chunk (8..40).
REQ-003 clk  in  1  single clock for all logic.
REQ-004 resetn  in  1  synchronous, active-low reset.
REQ-005 armaddr  in  32  register address; bits [7:2] select a word.
REQ-006 armwdata  in  32; armwr  in  1; armreq  in  1 (one-cycle request strobe); armwstrb  in  4 (byte enables).
REQ-007 armrdata  out  32; armack  out  1; armerr  out  1.
REQ-008 cstart  out  64*N  per-core chunk start key; core i at [64i+:64].
REQ-009 goal  out  64  shared target ciphertext.
REQ-010 crun  out  N  one-cycle start pulse per core.
REQ-011 cbusy  in  N; chit  in  N; cres  in  64*N  per-core busy, hit flag and found key.
REQ-012 irq  out  1  present only under DES_SCHED_IRQ_EN.

Function
REQ-013 armack SHALL pulse exactly one cycle after each armreq; armrdata and armerr are valid in that cycle.
REQ-014 Register map: 0x00 CTRL, 0x08/0x0C START lo/hi, 0x10/0x14 GOAL lo/hi, 0x18 NCHUNK, 0x20/0x24 RESULT lo/hi (RO), 0x28 DONECNT (RO), 0x2C NCORES (RO, =N); any other address SHALL assert armerr, ignore writes and read 0.
REQ-015 Writes honour armwstrb per byte; writes to START, GOAL and NCHUNK while busy SHALL be ignored without error.
REQ-016 CTRL write: bit0=go, bit1=abort; abort wins if both are set. CTRL read: bit0 busy, bit1 found, bit2 done, bit3 aborted.
REQ-017 FSM states: IDLE, DISPATCH, DRAIN, DONE. go in IDLE or DONE -> DISPATCH: clear found/done/aborted/DONECNT, set next-key = START, set remaining = NCHUNK.
REQ-018 In DISPATCH, each cycle the lowest-indexed core that is idle (cbusy low, not pulsed in the last 2 cycles) SHALL receive cstart = next-key and a crun pulse, followed by next-key += 2^CHUNKW (mod 2^64 wrap) and remaining -= 1; at most one issue per cycle.
REQ-019 A core's busy falling edge SHALL increment DONECNT. If chit is high at that edge, cres SHALL latch into RESULT and found is set; the lowest index wins when hits are simultaneous.
REQ-020 remaining = 0 or found -> DRAIN; DRAIN -> DONE once all cbusy are low and no crun was issued in the last 2 cycles.
REQ-021 NCHUNK = 0 with go SHALL pass directly to DONE in at most 2 cycles with found = 0.
REQ-022 abort in DISPATCH or DRAIN: stop issuing, set aborted, go to DRAIN; abort in IDLE or DONE has no effect. go while busy is ignored.
REQ-023 Hits arriving after found is set SHALL NOT overwrite RESULT.

Reset
REQ-024 With resetn low at a clk edge, all registers SHALL clear: FSM=IDLE, crun=0, armack=0, armerr=0, armrdata=0, cstart=0, goal=0, RESULT=0, DONECNT=0, irq=0.
REQ-025 Reset mid-job SHALL drop the job with no further crun pulses; cores are not signalled.

Configuration
REQ-026 Macro DES_SCHED_IRQ_EN defined: the irq port exists; irq is set on entry to DONE and cleared by any CTRL write, go, or reset.
REQ-027 Macro undefined: there is no irq port and no irq logic; all other behaviour is identical.

Structure
REQ-028 Shared package des_pkg holds the FSM state enum, register offsets, CTRL bit positions and the 64-bit key typedef.
REQ-029 Sub-module des_sched_regs implements the ARM register decode and ack/err; the FSM and dispatch logic sit in des_sched.

Verification
REQ-030 START=0, NCHUNK=3, N=4, CHUNKW=8, go -> cstart 0x000, 0x100, 0x200 on cores 0, 1, 2; core 3 gets no crun; DONECNT=3 and done=1 after the busies fall.
REQ-031 N=2, NCHUNK=5, cores busy for 10 cycles each -> 5 crun pulses total; round-robin reuse of the idle cores; DONECNT=5.
REQ-032 Core 1 returns chit=1 with cres=0x0123456789ABCDEF -> RESULT matches that value, found=1, no further crun pulses, done after drain.
REQ-033 Cores 0 and 2 hit in the same cycle -> RESULT = core 0 cres.
REQ-034 Read address 0x30 -> armerr=1, armrdata=0; write 0x08 with wstrb=0b0010 -> only START byte 1 changes.
REQ-035 Abort during DISPATCH -> aborted=1, no new crun pulses, DONE after the busies clear; START=0xFFFFFFFFFFFFFF00 with CHUNKW=8 and NCHUNK=2 -> second cstart wraps to 0.

Source files
------------

// File: rtl/des_pkg.sv
// Shared types and register map for the DES key-search scheduler.
// Optional IRQ output is enabled by defining DES_SCHED_IRQ_EN.
package des_pkg;

  typedef logic [63:0] key_t;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Word offsets (byte address >> 2)
  localparam logic [5:0] W_CTRL     = 6'h00;
  localparam logic [5:0] W_START_LO = 6'h02;
  localparam logic [5:0] W_START_HI = 6'h03;
  localparam logic [5:0] W_GOAL_LO  = 6'h04;
  localparam logic [5:0] W_GOAL_HI  = 6'h05;
  localparam logic [5:0] W_NCHUNK   = 6'h06;
  localparam logic [5:0] W_RES_LO   = 6'h08;
  localparam logic [5:0] W_RES_HI   = 6'h09;
  localparam logic [5:0] W_DONECNT  = 6'h0A;
  localparam logic [5:0] W_NCORES   = 6'h0B;

  localparam int CTRL_GO    = 0;
  localparam int CTRL_ABORT = 1;

  localparam int ST_BUSY    = 0;
  localparam int ST_FOUND   = 1;
  localparam int ST_DONE    = 2;
  localparam int ST_ABORTED = 3;

  function automatic logic [31:0] wmerge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  be
  );
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_sched_regs.sv
// ARM-side register file: decode, byte-strobed writes, ack/err.
// Config registers are frozen while a job is running.
module des_sched_regs
  import des_pkg::*;
#(
  parameter int N = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] armaddr,
  input  logic [31:0] armwdata,
  input  logic        armwr,
  input  logic        armreq,
  input  logic [3:0]  armwstrb,
  output logic [31:0] armrdata,
  output logic        armack,
  output logic        armerr,
  input  logic [3:0]  status,
  input  key_t        result,
  input  logic [31:0] donecnt,
  output key_t        start,
  output key_t        goal,
  output logic [31:0] nchunk,
  output logic        go,
  output logic        abort,
  output logic        ctrl_wr
);

  logic [5:0]  word;
  logic        s_ctrl, s_stlo, s_sthi;
  logic        s_golo, s_gohi, s_nch;
  logic        s_rslo, s_rshi, s_dcnt, s_ncor;
  logic        valid, wr, cfg_wr;
  logic [31:0] rd_val;
  logic        unused_addr;

  assign word        = armaddr[7:2];
  assign unused_addr = ^{armaddr[31:8], armaddr[1:0]};

  always_comb begin
    s_ctrl = (word == W_CTRL);
    s_stlo = (word == W_START_LO);
    s_sthi = (word == W_START_HI);
    s_golo = (word == W_GOAL_LO);
    s_gohi = (word == W_GOAL_HI);
    s_nch  = (word == W_NCHUNK);
    s_rslo = (word == W_RES_LO);
    s_rshi = (word == W_RES_HI);
    s_dcnt = (word == W_DONECNT);
    s_ncor = (word == W_NCORES);
    valid  = |{s_ctrl, s_stlo, s_sthi, s_golo,
               s_gohi, s_nch, s_rslo, s_rshi,
               s_dcnt, s_ncor};
  end

  always_comb begin
    wr      = armreq & armwr;
    cfg_wr  = wr & ~status[ST_BUSY];
    ctrl_wr = wr & s_ctrl;
    // abort and go share byte 0; abort takes priority
    abort   = ctrl_wr & armwstrb[0]
            & armwdata[CTRL_ABORT];
    go      = ctrl_wr & armwstrb[0]
            & armwdata[CTRL_GO]
            & ~armwdata[CTRL_ABORT];
  end

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      s_ctrl: rd_val = {28'd0, status};
      s_stlo: rd_val = start[31:0];
      s_sthi: rd_val = start[63:32];
      s_golo: rd_val = goal[31:0];
      s_gohi: rd_val = goal[63:32];
      s_nch:  rd_val = nchunk;
      s_rslo: rd_val = result[31:0];
      s_rshi: rd_val = result[63:32];
      s_dcnt: rd_val = donecnt;
      s_ncor: rd_val = 32'(N);
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      armack   <= 1'b0;
      armerr   <= 1'b0;
      armrdata <= '0;
      start    <= '0;
      goal     <= '0;
      nchunk   <= '0;
    end else begin
      armack   <= armreq;
      armerr   <= armreq & ~valid;
      armrdata <= (armreq && !armwr) ? rd_val : '0;
      if (cfg_wr) begin
        unique case (1'b1)
          s_stlo: start[31:0] <=
            wmerge(start[31:0], armwdata, armwstrb);
          s_sthi: start[63:32] <=
            wmerge(start[63:32], armwdata, armwstrb);
          s_golo: goal[31:0] <=
            wmerge(goal[31:0], armwdata, armwstrb);
          s_gohi: goal[63:32] <=
            wmerge(goal[63:32], armwdata, armwstrb);
          s_nch: nchunk <=
            wmerge(nchunk, armwdata, armwstrb);
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/des_sched.sv
// Chunk dispatcher for N DES cracker cores: FSM, issue and result capture.
// Define DES_SCHED_IRQ_EN to add the irq output.
module des_sched
  import des_pkg::*;
#(
  parameter int N      = 4,
  parameter int CHUNKW = 24
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     armaddr,
  input  logic [31:0]     armwdata,
  input  logic            armwr,
  input  logic            armreq,
  input  logic [3:0]      armwstrb,
  output logic [31:0]     armrdata,
  output logic            armack,
  output logic            armerr,
  output logic [64*N-1:0] cstart,
  output logic [63:0]     goal,
  output logic [N-1:0]    crun,
  input  logic [N-1:0]    cbusy,
  input  logic [N-1:0]    chit,
  input  logic [64*N-1:0] cres
`ifdef DES_SCHED_IRQ_EN
  ,
  output logic            irq
`endif
);

  localparam int   IW   = (N > 1) ? $clog2(N) : 1;
  localparam key_t STEP = key_t'(1) << CHUNKW;

  state_t      state, state_n;
  key_t        start, result, next_key;
  logic [31:0] nchunk, remaining, donecnt;
  logic [31:0] nfall;
  logic        found, aborted;
  logic        go, abort, ctrl_wr;
  logic [N-1:0] crun_d, busy_q;
  logic [N-1:0] fall, hits, avail;
  logic [IW-1:0] pick, hit_idx;
  logic        can_pick, hit_any;
  logic        active, issue, job_load;
  logic [3:0]  status;

  des_sched_regs #(.N(N)) u_regs (
    .clk      (clk),
    .resetn   (resetn),
    .armaddr  (armaddr),
    .armwdata (armwdata),
    .armwr    (armwr),
    .armreq   (armreq),
    .armwstrb (armwstrb),
    .armrdata (armrdata),
    .armack   (armack),
    .armerr   (armerr),
    .status   (status),
    .result   (result),
    .donecnt  (donecnt),
    .start    (start),
    .goal     (goal),
    .nchunk   (nchunk),
    .go       (go),
    .abort    (abort),
    .ctrl_wr  (ctrl_wr)
  );

  assign active = (state == S_DISPATCH)
               || (state == S_DRAIN);
  assign status = {aborted, state == S_DONE,
                   found, active};

  // A core pulsed in the last two cycles may not show busy yet
  always_comb begin
    fall     = busy_q & ~cbusy;
    hits     = fall & chit;
    avail    = ~cbusy & ~crun & ~crun_d;
    can_pick = |avail;
    hit_any  = |hits;
    pick     = '0;
    hit_idx  = '0;
    nfall    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (avail[i]) pick = IW'(i);
      if (hits[i])  hit_idx = IW'(i);
      nfall = nfall + 32'(fall[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (go) begin
          state_n = (nchunk == 32'd0) ? S_DRAIN
                                      : S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (abort || found || remaining == 32'd0)
          state_n = S_DRAIN;
      end
      S_DRAIN: begin
        if (cbusy == '0 && crun == '0 && crun_d == '0)
          state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    job_load = go && (state == S_IDLE
                   || state == S_DONE);
    issue    = (state == S_DISPATCH) && !abort
            && !found && !hit_any
            && (remaining != 32'd0) && can_pick;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crun      <= '0;
      crun_d    <= '0;
      busy_q    <= '0;
      cstart    <= '0;
      next_key  <= '0;
      remaining <= '0;
      donecnt   <= '0;
      result    <= '0;
      found     <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      crun   <= '0;
      crun_d <= crun;
      busy_q <= cbusy;
      if (job_load) begin
        next_key  <= start;
        remaining <= nchunk;
        donecnt   <= '0;
        found     <= 1'b0;
        aborted   <= 1'b0;
      end else begin
        if (issue) begin
          crun[pick] <= 1'b1;
          cstart[64*int'(pick) +: 64] <= next_key;
          next_key  <= next_key + STEP;
          remaining <= remaining - 32'd1;
        end
        if (active) begin
          donecnt <= donecnt + nfall;
          if (hit_any && !found) begin
            found  <= 1'b1;
            result <= cres[64*int'(hit_idx) +: 64];
          end
          if (abort) aborted <= 1'b1;
        end
      end
    end
  end

`ifdef DES_SCHED_IRQ_EN
  always_ff @(posedge clk) begin
    if (!resetn)
      irq <= 1'b0;
    else if (state_n == S_DONE && state != S_DONE)
      irq <= 1'b1;
    else if (ctrl_wr)
      irq <= 1'b0;
  end
`else
  logic unused_ctrl;
  assign unused_ctrl = ctrl_wr;
`endif

endmodule
